// File: rtl/psum_wb_pkg.sv
// Shared types and constants for the psum writeback block.
// The stall counter is built only when PSUM_WB_STALL_CNT_EN is defined.
package psum_wb_pkg;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;

    // The SRAM strobes are active-low.
    localparam logic SRAM_EN  = 1'b0;
    localparam logic SRAM_DIS = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/psum_wb_addr_cnt.sv
// Loadable wrap-around write address counter.
// It also tracks issued/remaining words and flags the last word.
module psum_wb_addr_cnt
    import psum_wb_pkg::*;
#(
    parameter int addr_w = ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [addr_w-1:0] base_addr,
    input  logic [addr_w:0]   num_words,
    input  logic              inc,
    output logic [addr_w-1:0] wr_addr,
    output logic              more,
    output logic              last
);

    localparam logic [addr_w-1:0] ADDR_ONE = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic [addr_w:0]   CNT_ONE  = {{addr_w{1'b0}}, 1'b1};

    logic [addr_w-1:0] wr_addr_q, wr_addr_d;
    logic [addr_w:0]   issued_q, issued_d;
    logic [addr_w:0]   remaining_q, remaining_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path infers a latch.
        wr_addr_d   = wr_addr_q;
        issued_d    = issued_q;
        remaining_d = remaining_q;
        if (load) begin
            wr_addr_d   = base_addr;
            remaining_d = num_words;
            issued_d    = '0;
        end else if (inc) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;   // wraps modulo 2^addr_w
            issued_d  = issued_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            wr_addr_q   <= '0;
            issued_q    <= '0;
            remaining_q <= '0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            issued_q    <= issued_d;
            remaining_q <= remaining_d;
        end
    end

    assign wr_addr = wr_addr_q;
    assign more    = (issued_q != remaining_q);
    assign last    = ((issued_q + CNT_ONE) == remaining_q);

endmodule

// File: rtl/psum_writeback.sv
// Drains OFIFO psum words into the psum SRAM at auto-incrementing addresses.
// Optional stall_cycles port/counter: define PSUM_WB_STALL_CNT_EN.
module psum_writeback
    import psum_wb_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int addr_w  = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [addr_w:0]        num_words,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_dout,
    output logic                   ofifo_rd,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_w-1:0]      sram_addr,
    output logic [col*psum_bw-1:0] sram_din,
    output logic                   busy,
`ifdef PSUM_WB_STALL_CNT_EN
    output logic [15:0]            stall_cycles,
`endif
    output logic                   done
);

    state_e                 state_q, state_d;
    logic                   sram_cen_q, sram_cen_d;
    logic                   sram_wen_q, sram_wen_d;
    logic [addr_w-1:0]      sram_addr_q, sram_addr_d;
    logic [col*psum_bw-1:0] sram_din_q, sram_din_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic              load;
    logic              pop;
    logic              cnt_more;
    logic              cnt_last;
    logic [addr_w-1:0] wr_addr;

    assign load = (state_q == IDLE) && start;
    // Combinational pop: the FIFO head is captured at the same edge it is popped.
    assign pop  = (state_q == DRAIN) && ofifo_valid && cnt_more;

    psum_wb_addr_cnt #(.addr_w(addr_w)) u_addr_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .base_addr (base_addr),
        .num_words (num_words),
        .inc       (pop),
        .wr_addr   (wr_addr),
        .more      (cnt_more),
        .last      (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        sram_cen_d  = SRAM_DIS;
        sram_wen_d  = SRAM_DIS;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = (num_words == '0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (pop) begin
                    sram_cen_d  = SRAM_EN;
                    sram_wen_d  = SRAM_EN;
                    sram_addr_d = wr_addr;
                    sram_din_d  = ofifo_dout;
                    if (cnt_last) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DRAIN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sram_cen_q  <= SRAM_DIS;
            sram_wen_q  <= SRAM_DIS;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sram_cen_q  <= sram_cen_d;
            sram_wen_q  <= sram_wen_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef PSUM_WB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (load)
            stall_d = '0;
        else if ((state_q == DRAIN) && !ofifo_valid && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

    assign ofifo_rd  = pop;
    assign sram_cen  = sram_cen_q;
    assign sram_wen  = sram_wen_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: table-driven drains, random drains
// against a pop/stall model, plus start-while-busy and reset-mid-drain sequences.
module tb_psum_writeback;
    import psum_wb_pkg::*;

    localparam int AW = ADDR_W;
    localparam int DW = COL * PSUM_BW;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          ofifo_valid;
    logic [DW-1:0] ofifo_dout;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic          busy;
    logic          done;
`ifdef PSUM_WB_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    psum_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .ofifo_valid  (ofifo_valid),
        .ofifo_dout   (ofifo_dout),
        .ofifo_rd     (ofifo_rd),
        .sram_cen     (sram_cen),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .busy         (busy),
`ifdef PSUM_WB_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bus monitor: records writes, pops and done pulses with their cycle index.
    int            cyc = 0;
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    int            wr_cyc_log[$];
    logic [DW-1:0] pop_data_log[$];
    int            pop_cyc_log[$];
    int            done_cnt, done_cyc, bad_rd, bad_en;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (!sram_cen && !sram_wen) begin
                wr_addr_log.push_back(sram_addr);
                wr_data_log.push_back(sram_din);
                wr_cyc_log.push_back(cyc);
            end
            if (ofifo_rd) begin
                pop_data_log.push_back(ofifo_dout);
                pop_cyc_log.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ofifo_rd && !busy) bad_rd++;
            if (sram_cen != sram_wen) bad_en++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
        pop_data_log.delete();
        pop_cyc_log.delete();
        done_cnt = 0;
        done_cyc = -1;
        bad_rd   = 0;
        bad_en   = 0;
    endtask

    logic [DW-1:0] words[64];

    task automatic fill_words;
        for (int i = 0; i < 64; i++)
            words[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic [DW-1:0] head_word();
        logic [5:0] idx;
        idx = 6'(pop_data_log.size());
        return words[idx];
    endfunction

    // Reference model: valid pattern bit k applies to the k-th DRAIN cycle
    // (valid stays high past bit 31). Each valid cycle pops one word, each
    // invalid one is a stall, until num words are popped.
    function automatic void model(input int num, input logic [31:0] pat,
                                  output int last_k, output int stalls);
        int pops = 0;
        int k    = 0;
        last_k = -1;
        stalls = 0;
        while (pops < num) begin
            if (k >= 32 || pat[k]) begin
                pops++;
                last_k = k;
            end else begin
                stalls++;
            end
            k++;
        end
    endfunction

    task automatic run_drain(input logic [AW-1:0] base, input int num, input logic [31:0] pat,
                             input int busy_k, input logic [AW-1:0] exp_last,
                             input int exp_stall, input string tag);
        int            start_cyc, last_k, stalls_m, k, exp_done;
        logic [AW-1:0] exp_a;
        fill_words();
        clear_mon();
        model(num, pat, last_k, stalls_m);
        start_cyc   = cyc;
        start       = 1'b1;
        base_addr   = base;
        num_words   = (AW+1)'(num);
        ofifo_valid = 1'b1;           // valid while IDLE must not cause a pop
        ofifo_dout  = words[0];
        tick();
        start       = 1'b0;
        base_addr   = AW'($urandom);
        num_words   = (AW+1)'($urandom);
        k = 0;
        while (done_cnt == 0 && k < 200) begin
            ofifo_valid = (k >= 32) ? 1'b1 : pat[k];
            ofifo_dout  = head_word();
            if (k == 0) check({tag, " busy_after_start"}, busy, (num != 0));
            if (k == busy_k) begin
                start     = 1'b1;
                base_addr = 11'h100;
                num_words = 12'd7;
            end
            tick();
            start = 1'b0;
            k++;
        end
        ofifo_valid = 1'b1;
        repeat (3) tick();
        ofifo_valid = 1'b0;

        check({tag, " pop_count"}, pop_data_log.size(), num);
        check({tag, " write_count"}, wr_addr_log.size(), num);
        exp_a = base;
        for (int i = 0; i < num && i < wr_addr_log.size() && i < pop_cyc_log.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), wr_addr_log[i], exp_a);
            check($sformatf("%s data[%0d]", tag, i), wr_data_log[i], words[i]);
            check($sformatf("%s latency[%0d]", tag, i), wr_cyc_log[i], pop_cyc_log[i] + 1);
            exp_a = exp_a + 1'b1;
        end
        if (num != 0 && wr_addr_log.size() != 0)
            check({tag, " last_addr"}, wr_addr_log[wr_addr_log.size()-1], exp_last);
        exp_done = (num == 0) ? start_cyc + 1 : start_cyc + 1 + last_k + 2;
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " rd_outside_drain"}, bad_rd, 0);
        check({tag, " cen_wen_pair"}, bad_en, 0);
`ifdef PSUM_WB_STALL_CNT_EN
        check({tag, " stall_cycles"}, stall_cycles, exp_stall);
        check({tag, " stall_model"}, stall_cycles, stalls_m);
`else
        if (exp_stall < 0) check({tag, " stall_arg"}, exp_stall, stalls_m);
`endif
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] base;
        int            num;
        logic [31:0]   pat;
        int            busy_k;
        logic [AW-1:0] exp_last;
        int            exp_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            last_k, st, num, bk;
        logic [AW-1:0] b;
        logic [31:0]   p;

        vecs[0] = '{"basic",  11'h010,  4, 32'hFFFF_FFFF, -1, 11'h013, 0};
        vecs[1] = '{"bubble", 11'h040,  3, 32'h0000_0029, -1, 11'h042, 3};
        vecs[2] = '{"wrap",   11'd2046, 4, 32'hFFFF_FFFF, -1, 11'd1,   0};
        vecs[3] = '{"zero",   11'h077,  0, 32'hFFFF_FFFF, -1, 11'h000, 0};
        vecs[4] = '{"busy",   11'h050,  4, 32'hFFFF_FFFF,  1, 11'h053, 0};
        vecs[5] = '{"single", 11'h7FF,  1, 32'hFFFF_FFFC, -1, 11'h7FF, 2};

        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_words   = '0;
        ofifo_valid = 1'b1;
        ofifo_dout  = '1;
        clear_mon();
        repeat (3) tick();
        check("reset cen", sram_cen, 1'b1);
        check("reset wen", sram_wen, 1'b1);
        check("reset addr", sram_addr, '0);
        check("reset din", sram_din, '0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset rd", ofifo_rd, 1'b0);
`ifdef PSUM_WB_STALL_CNT_EN
        check("reset stall", stall_cycles, 16'd0);
`endif
        reset       = 1'b0;
        ofifo_valid = 1'b0;
        tick();

        for (int v = 0; v < 6; v++)
            run_drain(vecs[v].base, vecs[v].num, vecs[v].pat, vecs[v].busy_k,
                      vecs[v].exp_last, vecs[v].exp_stall, vecs[v].name);

        // Reset mid-drain, then a fresh two-word drain from a new base.
        fill_words();
        clear_mon();
        start       = 1'b1;
        base_addr   = 11'h020;
        num_words   = 12'd5;
        ofifo_valid = 1'b1;
        ofifo_dout  = words[0];
        tick();
        start = 1'b0;
        for (int n = 0; n < 20 && wr_addr_log.size() < 2; n++) begin
            ofifo_dout = head_word();
            tick();
        end
        check("midrst writes_before", (wr_addr_log.size() >= 2), 1'b1);
        reset = 1'b1;
        tick();
        check("midrst cen", sram_cen, 1'b1);
        check("midrst wen", sram_wen, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst rd", ofifo_rd, 1'b0);
`ifdef PSUM_WB_STALL_CNT_EN
        check("midrst stall", stall_cycles, 16'd0);
`endif
        reset = 1'b0;
        tick();
        run_drain(11'h300, 2, 32'hFFFF_FFFF, -1, 11'h301, 0, "restart");

        for (int r = 0; r < 20; r++) begin
            b   = AW'($urandom);
            num = $urandom_range(0, 12);
            p   = $urandom | $urandom;
            bk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
            model(num, p, last_k, st);
            run_drain(b, num, p, bk, b + AW'(num - 1), st, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
